// File: rtl/yapp_input_arbiter.sv
// yapp_input_arbiter
//   Shares the router's single YAPP input port between NUM_SRC packet sources.
//   Round-robin arbitration happens only between packets: once a source is
//   granted, the grant is held until the parity byte of its packet has moved.
//   Packet boundaries come from the header length field
//   (header = {len[7:2], addr[1:0]}, total bytes = len + 2).
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        synchronous, active-high
//   src_data     byte i of source i is src_data[8*i+7:8*i]
//   src_vld      per-source "byte valid"
//   src_ready    per-source "byte consumed this cycle"
//   in_data      byte to the router YAPP input
//   in_data_vld  valid to the router YAPP input
//   in_suspend   router back-pressure, high = byte not accepted
//   grant_id     index of the current / last granted source
//   busy         high while a packet is being passed through (XFER)
//   pkt_done     one-cycle pulse on the transfer of a packet's parity byte
//   dbg_state    FSM state (0 IDLE, 1 XFER, 2 GAP) for checkers
//
// Handshake: a byte moves on a rising edge where in_data_vld=1 and
// in_suspend=0. src_ready[g] is exactly that condition for the granted source
// g and is 0 for every other source; a source must hold its byte and src_vld
// until it sees src_ready. Dropping src_vld mid-packet only stalls the port.

module yapp_input_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_vld,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [7:0]             in_data,
  output logic                   in_data_vld,
  input  logic                   in_suspend,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [6:0]  rem_q, rem_d;        // bytes still to move after the header
  logic        hdr_seen_q, hdr_seen_d;
  logic [3:0]  gap_q, gap_d;

  logic [2:0]  winner;
  logic [2:0]  hi_win;
  logic [2:0]  any_win;
  logic        hi_found;
  logic [7:0]  sel_data;
  logic        sel_vld;
  logic        xfer;

  // Round-robin pick: lowest requesting index above last_grant, otherwise
  // wrap to the lowest requesting index overall.
  always_comb begin
    hi_win   = 3'd0;
    any_win  = 3'd0;
    hi_found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_vld[i]) begin
        any_win = i[2:0];
      end
      if (src_vld[i] && (i[2:0] > last_grant_q)) begin
        hi_win   = i[2:0];
        hi_found = 1'b1;
      end
    end
    winner = hi_found ? hi_win : any_win;
  end

  // Granted source's byte and valid.
  always_comb begin
    sel_data = 8'h00;
    sel_vld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == i[2:0]) begin
        sel_data = src_data[8*i +: 8];
        sel_vld  = src_vld[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    hdr_seen_d   = hdr_seen_q;
    gap_d        = gap_q;
    in_data      = 8'h00;
    in_data_vld  = 1'b0;
    pkt_done     = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|src_vld) begin
          grant_d    = winner;
          rem_d      = 7'd0;
          hdr_seen_d = 1'b0;
          state_d    = ST_XFER;
        end
      end

      ST_XFER: begin
        in_data     = sel_data;
        in_data_vld = sel_vld;
        xfer        = sel_vld && !in_suspend;
        if (xfer) begin
          if (!hdr_seen_q) begin
            // len payload bytes plus parity still follow the header;
            // len=63 gives 64, which fits in 7 bits.
            hdr_seen_d = 1'b1;
            rem_d      = {1'b0, sel_data[7:2]} + 7'd1;
          end else if (rem_q == 7'd1) begin
            // This transfer takes the count to zero: it is the parity byte.
            pkt_done     = 1'b1;
            rem_d        = 7'd0;
            hdr_seen_d   = 1'b0;
            last_grant_d = grant_q;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = 4'(GAP_CYCLES - 1);
            end
          end else begin
            rem_d = rem_q - 7'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = xfer && (grant_q == i[2:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_SRC - 1);  // source 0 wins the first arbitration
      rem_q        <= 7'd0;
      hdr_seen_q   <= 1'b0;
      gap_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      hdr_seen_q   <= hdr_seen_d;
      gap_q        <= gap_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_yapp_input_arbiter.sv
// Bench for yapp_input_arbiter (NUM_SRC=2, GAP_CYCLES=1).
// Sources are modelled as byte queues presented on the falling edge; outputs
// are sampled 2 time units later, well before the next rising edge. Every
// expected transfer is queued as {pkt_done, source, byte} when a packet is
// generated, and popped when the port moves a byte.

module tb_yapp_input_arbiter;

  localparam int NUM_SRC = 2;
  localparam int GAP     = 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [8*NUM_SRC-1:0] src_data = '0;
  logic [NUM_SRC-1:0]   src_vld = '0;
  logic [NUM_SRC-1:0]   src_ready;
  logic [7:0]           in_data;
  logic                 in_data_vld;
  logic                 in_suspend;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 pkt_done;
  logic [1:0]           dbg_state;

  yapp_input_arbiter #(.NUM_SRC(NUM_SRC), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .reset       (reset),
    .src_data    (src_data),
    .src_vld     (src_vld),
    .src_ready   (src_ready),
    .in_data     (in_data),
    .in_data_vld (in_data_vld),
    .in_suspend  (in_suspend),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pkt_bytes = 0;
  logic [11:0] exp_q[$];
  int          exp_len_q[$];
  logic [7:0]  src_q0[$];
  logic [7:0]  src_q1[$];
  int          xfer_cyc_q[$];
  logic [1:0]  stall = '0;
  logic [1:0]  st_log [0:4095];
  logic        vld_log [0:4095];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input int src, input logic [7:0] b, input logic done);
    if (src == 0) src_q0.push_back(b);
    else          src_q1.push_back(b);
    exp_q.push_back({done, 3'(src), b});
  endtask

  task automatic gen_pkt(input int src, input logic [7:0] hdr);
    logic [7:0] b;
    logic [7:0] par;
    int         len;
    len = int'(hdr[7:2]);
    par = hdr;
    push_byte(src, hdr, 1'b0);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom_range(0, 255));
      par = par ^ b;
      push_byte(src, b, 1'b0);
    end
    push_byte(src, par, 1'b1);
    exp_len_q.push_back(len + 2);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || dbg_state != ST_IDLE) && n < budget) begin
      step(1);
      n++;
    end
    check("drain", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_bytes(input int nb);
    int n;
    n = 0;
    while (pkt_bytes != nb && n < 100) begin
      step(1);
      n++;
    end
    check("wait_bytes", 32'(pkt_bytes), 32'(nb));
  endtask

  // ---------------- source model + monitor ----------------
  always @(negedge clock) begin
    logic        xfer;
    logic [11:0] e;
    logic [7:0]  dummy;
    int          el;
    cyc++;
    src_vld[0]     = (src_q0.size() > 0) && !stall[0];
    src_vld[1]     = (src_q1.size() > 0) && !stall[1];
    src_data[7:0]  = (src_q0.size() > 0) ? src_q0[0] : 8'h00;
    src_data[15:8] = (src_q1.size() > 0) ? src_q1[0] : 8'h00;
    #2;
    st_log[cyc & 4095]  = dbg_state;
    vld_log[cyc & 4095] = in_data_vld;
    if (reset) begin
      pkt_bytes = 0;
    end else begin
      xfer = in_data_vld && !in_suspend;
      check("src_ready", 32'(src_ready), xfer ? (32'd1 << grant_id) : 32'd0);
      if (!busy) begin
        check("idle_vld", 32'(in_data_vld), 32'd0);
        check("idle_data", 32'(in_data), 32'd0);
      end
      if (in_data_vld && in_suspend && exp_q.size() > 0) begin
        check("hold_data", 32'(in_data), 32'(exp_q[0][7:0]));
      end
      if (!xfer) begin
        check("stray_done", 32'(pkt_done), 32'd0);
      end else begin
        check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("xfer", 32'({pkt_done, grant_id, in_data}), 32'(e));
        end
        if (src_ready[0] && src_q0.size() > 0) dummy = src_q0.pop_front();
        if (src_ready[1] && src_q1.size() > 0) dummy = src_q1.pop_front();
        pkt_bytes++;
        xfer_cyc_q.push_back(cyc);
        if (pkt_done) begin
          if (exp_len_q.size() > 0) begin
            el = exp_len_q.pop_front();
            check("pkt_len", 32'(pkt_bytes), 32'(el));
          end
          pkt_bytes = 0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c;
    reset      = 1'b1;
    in_suspend = 1'b0;
    step(3);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(in_data_vld), 32'd0);
    check("rst_data", 32'(in_data), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    step(1);

    // 1: single len-4 packet, latency, back-to-back transfers, one gap cycle
    c = cyc;
    xfer_cyc_q.delete();
    gen_pkt(0, 8'h11);
    wait_drain(50);
    step(3);
    check("t1_count", 32'(xfer_cyc_q.size()), 32'd6);
    if (xfer_cyc_q.size() == 6) begin
      check("t1_first", 32'(xfer_cyc_q[0]), 32'(c + 2));
      check("t1_last", 32'(xfer_cyc_q[5]), 32'(c + 7));
    end
    check("t1_gap_state", 32'(st_log[(c + 8) & 4095]), 32'(ST_GAP));
    check("t1_gap_vld", 32'(vld_log[(c + 8) & 4095]), 32'd0);
    check("t1_idle", 32'(st_log[(c + 9) & 4095]), 32'(ST_IDLE));

    // 2: both sources with 3 packets each from reset -> 0,1,0,1,0,1
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      gen_pkt(0, {6'($urandom_range(0, 5)), 2'(k)});
      gen_pkt(1, {6'($urandom_range(0, 5)), 2'(k + 1)});
    end
    wait_drain(300);

    // 3: suspend for 4 cycles after the 2nd payload byte of a len-3 packet
    gen_pkt(0, {6'd3, 2'd1});
    wait_bytes(3);
    in_suspend = 1'b1;
    repeat (4) begin
      step(1);
      check("t3_ready", 32'(src_ready), 32'd0);
      check("t3_vld", 32'(in_data_vld), 32'd1);
      check("t3_done", 32'(pkt_done), 32'd0);
    end
    in_suspend = 1'b0;
    wait_drain(50);

    // 4: length boundaries
    gen_pkt(0, 8'h02);
    wait_drain(50);
    gen_pkt(0, 8'hFC);
    wait_drain(200);

    // 5: granted src1 stalls 3 cycles while src0 requests
    gen_pkt(1, {6'd4, 2'd1});
    wait_bytes(2);
    stall[1] = 1'b1;
    gen_pkt(0, {6'd2, 2'd0});
    repeat (3) begin
      step(1);
      check("t5_grant", 32'(grant_id), 32'd1);
      check("t5_vld", 32'(in_data_vld), 32'd0);
      check("t5_ready", 32'(src_ready), 32'd0);
    end
    stall[1] = 1'b0;
    wait_drain(100);

    // 6: reset mid-packet, then simultaneous requests -> src0 first
    gen_pkt(0, {6'd4, 2'd3});
    wait_bytes(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    src_q0.delete();
    exp_q.delete();
    exp_len_q.delete();
    check("t6_vld", 32'(in_data_vld), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    gen_pkt(0, {6'd1, 2'd0});
    gen_pkt(1, {6'd1, 2'd1});
    wait_drain(100);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
